// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared state encodings and constants for the fetch sequencer
package fetch_sequencer_pkg;

  localparam logic [1:0] ST_ISSUE  = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  localparam logic [15:0] NOP_INSTR = 16'h0800;

  // Instructions are halfword aligned; bit 0 of any target is meaningless.
  function automatic logic [15:0] align_pc(input logic [15:0] addr);
    return addr & 16'hFFFE;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction memory request/response bus
interface fetch_sequencer_if;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_done;
  logic [15:0] imem_data;

  modport master (output imem_req, output imem_addr, input imem_done, input imem_data);
  modport slave  (input imem_req, input imem_addr, output imem_done, output imem_data);

endinterface

// File: rtl/fetch_sequencer_rca_16b.sv
// rtl/fetch_sequencer_rca_16b.sv - 16-bit ripple-carry adder; carry out is discarded so sums wrap
module fetch_sequencer_rca_16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum
);

  logic [15:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < 16; i++) begin : g_sum
    assign sum[i] = a[i] ^ b[i] ^ carry[i];
  end

  for (genvar i = 0; i < 15; i++) begin : g_carry
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and instruction fetch sequencer between the PC adder and IF/ID
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [15:0]       redirect_pc,
  fetch_sequencer_if.master imem,
  output logic [15:0]       pc,
  output logic [15:0]       instr,
  output logic [15:0]       instr_pc_plus2,
  output logic              instr_valid,
  output logic              halted
);

  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] ipp2_q, ipp2_d;
  logic        instr_valid_q, instr_valid_d;
  logic [15:0] hold_q, hold_d;
  logic        redir_pend_q, redir_pend_d;
  logic [15:0] redir_pc_q, redir_pc_d;
  logic        halted_q, halted_d;

  logic [15:0] pc_plus2;
  logic [15:0] redirect_tgt;
  logic [15:0] done_tgt;
  logic        issue_req;

  fetch_sequencer_rca_16b u_pc_adder (
    .a    (pc_q),
    .b    (16'h0002),
    .c_in (1'b0),
    .sum  (pc_plus2)
  );

  assign redirect_tgt = align_pc(redirect_pc);
  // A live redirect is newer than any pending one.
  assign done_tgt     = redirect_valid ? redirect_tgt : redir_pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    ipp2_d        = ipp2_q;
    instr_valid_d = stall ? instr_valid_q : 1'b0;
    hold_d        = hold_q;
    redir_pend_d  = redir_pend_q;
    redir_pc_d    = redir_pc_q;
    halted_d      = halted_q;
    issue_req     = 1'b0;

    case (state_q)
      ST_ISSUE: begin
        if (redirect_valid) begin
          pc_d          = redirect_tgt;
          instr_valid_d = 1'b0;
        end else if (halt) begin
          state_d       = ST_HALTED;
          halted_d      = 1'b1;
          instr_valid_d = 1'b0;
        end else if (!stall) begin
          issue_req = 1'b1;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem.imem_done) begin
          if (redir_pend_q || redirect_valid) begin
            instr_valid_d = 1'b0;
            pc_d          = done_tgt;
            redir_pend_d  = 1'b0;
            state_d       = ST_ISSUE;
          end else if (halt) begin
            instr_valid_d = 1'b0;
            halted_d      = 1'b1;
            state_d       = ST_HALTED;
          end else if (stall) begin
            hold_d  = imem.imem_data;
            state_d = ST_HOLD;
          end else begin
            instr_d       = imem.imem_data;
            ipp2_d        = pc_plus2;
            instr_valid_d = 1'b1;
            pc_d          = pc_plus2;
            state_d       = ST_ISSUE;
          end
        end else if (redirect_valid) begin
          redir_pend_d = 1'b1;
          redir_pc_d   = redirect_tgt;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          instr_valid_d = 1'b0;
          pc_d          = redirect_tgt;
          state_d       = ST_ISSUE;
        end else if (!stall) begin
          instr_d       = hold_q;
          ipp2_d        = pc_plus2;
          instr_valid_d = 1'b1;
          pc_d          = pc_plus2;
          state_d       = ST_ISSUE;
        end
      end
      default: begin
        instr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_ISSUE;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      ipp2_q        <= 16'h0000;
      instr_valid_q <= 1'b0;
      hold_q        <= 16'h0000;
      redir_pend_q  <= 1'b0;
      redir_pc_q    <= 16'h0000;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      ipp2_q        <= ipp2_d;
      instr_valid_q <= instr_valid_d;
      hold_q        <= hold_d;
      redir_pend_q  <= redir_pend_d;
      redir_pc_q    <= redir_pc_d;
      halted_q      <= halted_d;
    end
  end

  // Request is a combinational pulse from ISSUE, masked while reset is held.
  assign imem.imem_req  = issue_req && rst;
  assign imem.imem_addr = pc_q;

  assign pc             = pc_q;
  assign instr          = instr_q;
  assign instr_pc_plus2 = ipp2_q;
  assign instr_valid    = instr_valid_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        halt;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] pc;
  logic [15:0] instr;
  logic [15:0] instr_pc_plus2;
  logic        instr_valid;
  logic        halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_sequencer_if imem_bus ();

  fetch_sequencer #(.RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem_bus),
    .pc             (pc),
    .instr          (instr),
    .instr_pc_plus2 (instr_pc_plus2),
    .instr_valid    (instr_valid),
    .halted         (halted)
  );

  task automatic test_reset();
    rst = 1'b0; stall = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
    imem_bus.imem_done = 1'b0; imem_bus.imem_data = 16'h0000;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h expected 0000", pc); end
    checks++; if (instr !== 16'h0800) begin errors++; $display("FAIL reset_instr: got %h expected 0800", instr); end
    checks++; if (instr_pc_plus2 !== 16'h0000) begin errors++; $display("FAIL reset_ipp2: got %h expected 0000", instr_pc_plus2); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_bus.imem_req); end
  endtask

  task automatic test_sequential();
    logic [15:0] exp_addr, exp_instr;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_addr  = 16'(2 * k);
      exp_instr = 16'h1000 + 16'(k) - 16'h0001;
      checks++; if (imem_bus.imem_req !== 1'b1) begin errors++; $display("FAIL seq_req k=%0d: got %b expected 1", k, imem_bus.imem_req); end
      checks++; if (imem_bus.imem_addr !== exp_addr) begin errors++; $display("FAIL seq_addr k=%0d: got %h expected %h", k, imem_bus.imem_addr, exp_addr); end
      if (k > 0) begin
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid k=%0d: got %b expected 1", k, instr_valid); end
        checks++; if (instr !== exp_instr) begin errors++; $display("FAIL seq_instr k=%0d: got %h expected %h", k, instr, exp_instr); end
        checks++; if (instr_pc_plus2 !== exp_addr) begin errors++; $display("FAIL seq_ipp2 k=%0d: got %h expected %h", k, instr_pc_plus2, exp_addr); end
      end
      @(negedge clk);
      imem_bus.imem_done = 1'b1; imem_bus.imem_data = 16'h1000 + 16'(k);
      #1;
      checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL seq_wait_req k=%0d: got %b expected 0", k, imem_bus.imem_req); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL seq_wait_valid k=%0d: got %b expected 0", k, instr_valid); end
      @(negedge clk);
      imem_bus.imem_done = 1'b0;
      #1;
    end
    checks++; if (instr !== 16'h1003) begin errors++; $display("FAIL seq_last_instr: got %h expected 1003", instr); end
    checks++; if (pc !== 16'h0008) begin errors++; $display("FAIL seq_last_pc: got %h expected 0008", pc); end
  endtask

  task automatic test_redirect_wait();
    @(negedge clk); #1;
    checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL rdw_wait_req: got %b expected 0", imem_bus.imem_req); end
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 16'h0041;
    #1;
    @(negedge clk);
    redirect_valid = 1'b0; imem_bus.imem_done = 1'b1; imem_bus.imem_data = 16'hDEAD;
    #1;
    @(negedge clk);
    imem_bus.imem_done = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rdw_valid: got %b expected 0", instr_valid); end
    checks++; if (pc !== 16'h0040) begin errors++; $display("FAIL rdw_pc: got %h expected 0040", pc); end
    checks++; if (imem_bus.imem_req !== 1'b1) begin errors++; $display("FAIL rdw_req: got %b expected 1", imem_bus.imem_req); end
    checks++; if (imem_bus.imem_addr !== 16'h0040) begin errors++; $display("FAIL rdw_addr: got %h expected 0040", imem_bus.imem_addr); end
    @(negedge clk);
    imem_bus.imem_done = 1'b1; imem_bus.imem_data = 16'h2222;
    #1;
    @(negedge clk);
    imem_bus.imem_done = 1'b0;
    #1;
    checks++; if (instr !== 16'h2222) begin errors++; $display("FAIL rdw_next_instr: got %h expected 2222", instr); end
    checks++; if (pc !== 16'h0042) begin errors++; $display("FAIL rdw_next_pc: got %h expected 0042", pc); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    #1;
    checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_issue_req: got %b expected 0", imem_bus.imem_req); end
    @(negedge clk); #1;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_issue_valid: got %b expected 1", instr_valid); end
    checks++; if (instr !== 16'h2222) begin errors++; $display("FAIL stall_issue_instr: got %h expected 2222", instr); end
    checks++; if (pc !== 16'h0042) begin errors++; $display("FAIL stall_issue_pc: got %h expected 0042", pc); end
    stall = 1'b0;
    #1;
    checks++; if (imem_bus.imem_addr !== 16'h0042) begin errors++; $display("FAIL stall_addr: got %h expected 0042", imem_bus.imem_addr); end
    @(negedge clk);
    imem_bus.imem_done = 1'b1; imem_bus.imem_data = 16'hA5A5; stall = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      imem_bus.imem_done = 1'b0;
      #1;
      checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_hold_req i=%0d: got %b expected 0", i, imem_bus.imem_req); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stall_hold_valid i=%0d: got %b expected 0", i, instr_valid); end
      checks++; if (pc !== 16'h0042) begin errors++; $display("FAIL stall_hold_pc i=%0d: got %h expected 0042", i, pc); end
    end
    stall = 1'b0;
    @(negedge clk); #1;
    checks++; if (instr !== 16'hA5A5) begin errors++; $display("FAIL stall_rel_instr: got %h expected a5a5", instr); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_rel_valid: got %b expected 1", instr_valid); end
    checks++; if (pc !== 16'h0044) begin errors++; $display("FAIL stall_rel_pc: got %h expected 0044", pc); end
    checks++; if (instr_pc_plus2 !== 16'h0044) begin errors++; $display("FAIL stall_rel_ipp2: got %h expected 0044", instr_pc_plus2); end
  endtask

  task automatic test_halt();
    int reqs;
    @(negedge clk);
    halt = 1'b1;
    #1;
    @(negedge clk);
    imem_bus.imem_done = 1'b1; imem_bus.imem_data = 16'hBEEF;
    #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early: got %b expected 0", halted); end
    @(negedge clk);
    imem_bus.imem_done = 1'b0;
    #1;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_level: got %b expected 1", halted); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL halt_valid: got %b expected 0", instr_valid); end
    reqs = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (imem_bus.imem_req === 1'b1) reqs++;
    end
    checks++; if (reqs !== 0) begin errors++; $display("FAIL halt_no_req: got %0d requests expected 0", reqs); end
    checks++; if (pc !== 16'h0044) begin errors++; $display("FAIL halt_pc_frozen: got %h expected 0044", pc); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %b expected 1", halted); end
  endtask

  task automatic test_redirect_halt();
    rst = 1'b0;
    #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rh_reset_halted: got %b expected 0", halted); end
    @(negedge clk);
    rst = 1'b1; halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0100;
    #1;
    checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL rh_req: got %b expected 0", imem_bus.imem_req); end
    @(negedge clk); #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rh_halted: got %b expected 0", halted); end
    checks++; if (pc !== 16'h0100) begin errors++; $display("FAIL rh_pc: got %h expected 0100", pc); end
    halt = 1'b0; redirect_valid = 1'b0;
    #1;
    checks++; if (imem_bus.imem_addr !== 16'h0100) begin errors++; $display("FAIL rh_addr: got %h expected 0100", imem_bus.imem_addr); end
  endtask

  task automatic test_wrap_and_reset();
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    #1;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_bus.imem_addr !== 16'hFFFE) begin errors++; $display("FAIL wrap_addr0: got %h expected fffe", imem_bus.imem_addr); end
    @(negedge clk);
    imem_bus.imem_done = 1'b1; imem_bus.imem_data = 16'h1234;
    #1;
    @(negedge clk);
    imem_bus.imem_done = 1'b0;
    #1;
    checks++; if (imem_bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_addr: got %h expected 0000", imem_bus.imem_addr); end
    checks++; if (instr_pc_plus2 !== 16'h0000) begin errors++; $display("FAIL wrap_ipp2: got %h expected 0000", instr_pc_plus2); end
    checks++; if (instr !== 16'h1234) begin errors++; $display("FAIL wrap_instr: got %h expected 1234", instr); end
    @(negedge clk);
    imem_bus.imem_done = 1'b1; imem_bus.imem_data = 16'h5678;
    #1;
    @(negedge clk);
    imem_bus.imem_done = 1'b0;
    #1;
    checks++; if (pc !== 16'h0002) begin errors++; $display("FAIL wrap_next_pc: got %h expected 0002", pc); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL midwait_pc: got %h expected 0000", pc); end
    checks++; if (instr !== 16'h0800) begin errors++; $display("FAIL midwait_instr: got %h expected 0800", instr); end
    checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL midwait_req: got %b expected 0", imem_bus.imem_req); end
    @(negedge clk);
    rst = 1'b1; imem_bus.imem_done = 1'b1; imem_bus.imem_data = 16'h9999;
    #1;
    checks++; if (imem_bus.imem_req !== 1'b1) begin errors++; $display("FAIL late_done_req: got %b expected 1", imem_bus.imem_req); end
    @(negedge clk);
    imem_bus.imem_done = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL late_done_valid: got %b expected 0", instr_valid); end
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL late_done_pc: got %h expected 0000", pc); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect_wait();
    test_stall();
    test_halt();
    test_redirect_halt();
    test_wrap_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
